// File: rtl/lock_pkg.sv
// Symbol codes shared by the lock FSM and the seven-segment scan driver,
// plus the active-low segment pattern for a dark digit.
package lock_pkg;

  typedef logic [4:0] sym_t;

  localparam sym_t SYM_0     = 5'd0;
  localparam sym_t SYM_1     = 5'd1;
  localparam sym_t SYM_2     = 5'd2;
  localparam sym_t SYM_3     = 5'd3;
  localparam sym_t SYM_4     = 5'd4;
  localparam sym_t SYM_5     = 5'd5;
  localparam sym_t SYM_6     = 5'd6;
  localparam sym_t SYM_7     = 5'd7;
  localparam sym_t SYM_8     = 5'd8;
  localparam sym_t SYM_9     = 5'd9;
  localparam sym_t SYM_A     = 5'd10;
  localparam sym_t SYM_B     = 5'd11;
  localparam sym_t SYM_C     = 5'd12;
  localparam sym_t SYM_D     = 5'd13;
  localparam sym_t SYM_E     = 5'd14;
  localparam sym_t SYM_F     = 5'd15;
  localparam sym_t SYM_L     = 5'd16;
  localparam sym_t SYM_S     = 5'd17;
  localparam sym_t SYM_O     = 5'd18;
  localparam sym_t SYM_P     = 5'd19;
  localparam sym_t SYM_N     = 5'd20;
  localparam sym_t SYM_TIRE  = 5'd21;
  localparam sym_t SYM_BLANK = 5'd22;
  localparam sym_t SYM_V     = 5'd23;

  // Segment order {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/sym2seg.sv
// Combinational 5-bit symbol code to active-low {g,f,e,d,c,b,a} segment decode.
// Codes 24..31 and the explicit blank code render dark.
module sym2seg
  import lock_pkg::*;
(
  input  logic [4:0] i_sym,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_sym)
      SYM_0:    o_seg = 7'b1000000;
      SYM_1:    o_seg = 7'b1111001;
      SYM_2:    o_seg = 7'b0100100;
      SYM_3:    o_seg = 7'b0110000;
      SYM_4:    o_seg = 7'b0011001;
      SYM_5:    o_seg = 7'b0010010;
      SYM_6:    o_seg = 7'b0000010;
      SYM_7:    o_seg = 7'b1111000;
      SYM_8:    o_seg = 7'b0000000;
      SYM_9:    o_seg = 7'b0010000;
      SYM_A:    o_seg = 7'b0001000;
      SYM_B:    o_seg = 7'b0000011;
      SYM_C:    o_seg = 7'b1000110;
      SYM_D:    o_seg = 7'b0100001;
      SYM_E:    o_seg = 7'b0000110;
      SYM_F:    o_seg = 7'b0001110;
      SYM_L:    o_seg = 7'b1000111;
      SYM_S:    o_seg = 7'b0010010;
      SYM_O:    o_seg = 7'b1000000;
      SYM_P:    o_seg = 7'b0001100;
      SYM_N:    o_seg = 7'b0101011;
      SYM_TIRE: o_seg = 7'b0111111;
      SYM_V:    o_seg = 7'b1000001;
      default:  o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed seven-segment driver: one guard cycle per dwell, frame-atomic ssd snapshot,
// registered an/seg (1 cycle latency). Optional blinking when SSD_SCAN_DRIVER_BLINK_EN is defined.
module ssd_scan_driver
  import lock_pkg::*;
#(
  parameter int DWELL      = 50000,
  parameter int BLINK_HALF = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] ssd,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int DW_W = $clog2(DWELL);

  logic [DW_W-1:0] r_dcnt;
  logic [1:0]      r_idx;
  logic [19:0]     r_sh_ssd;
  logic            w_dwrap;
  logic            w_snap;
  logic            w_vis;
  logic [4:0]      w_sym;
  logic [6:0]      w_seg;

  assign w_dwrap = (r_dcnt == DW_W'(DWELL - 1));
  assign w_snap  = w_dwrap && (r_idx == 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dcnt   <= '0;
      r_idx    <= 2'd3;
      r_sh_ssd <= {4{SYM_BLANK}};
    end else begin
      r_dcnt <= w_dwrap ? '0 : r_dcnt + DW_W'(1);
      if (w_dwrap) r_idx <= r_idx - 2'd1;
      // Snapshot only at the 0->3 wrap so a frame never mixes two ssd values.
      if (w_snap) r_sh_ssd <= ssd;
    end
  end

  always_comb begin
    w_sym = r_sh_ssd[4:0];
    case (r_idx)
      2'd3:    w_sym = r_sh_ssd[19:15];
      2'd2:    w_sym = r_sh_ssd[14:10];
      2'd1:    w_sym = r_sh_ssd[9:5];
      default: w_sym = r_sh_ssd[4:0];
    endcase
  end

  sym2seg u_sym2seg (
    .i_sym (w_sym),
    .o_seg (w_seg)
  );

`ifdef SSD_SCAN_DRIVER_BLINK_EN
  localparam int BW_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [BW_W-1:0] r_bcnt;
  logic            r_phase;
  logic [3:0]      r_sh_mask;
  logic            w_bwrap;

  assign w_bwrap = (r_bcnt == BW_W'(BLINK_HALF - 1));

  // Free-running blink timebase, independent of the scan and of ssd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcnt    <= '0;
      r_phase   <= 1'b1;
      r_sh_mask <= '0;
    end else begin
      r_bcnt <= w_bwrap ? '0 : r_bcnt + BW_W'(1);
      if (w_bwrap) r_phase <= ~r_phase;
      if (w_snap) r_sh_mask <= blink_mask;
    end
  end

  assign w_vis = r_phase || !r_sh_mask[r_idx];
`else
  localparam int unused_blink_half = BLINK_HALF;
  logic w_unused_mask;

  assign w_unused_mask = ^blink_mask;
  assign w_vis         = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else if ((r_dcnt == '0) || !w_vis) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(4'b0001 << r_idx);
      seg <= w_seg;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver at DWELL=4, BLINK_HALF=16; expected an/seg per cycle are queued
// frame by frame from a glyph table and popped as the DUT produces each output.
module tb_ssd_scan_driver;

  localparam int DW = 4;
  localparam int BH = 16;
  localparam int FRAME = 4 * DW;
  localparam int NVEC = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] ssd;
  logic [3:0]  blink_mask;
  logic [3:0]  an;
  logic [6:0]  seg;

  always #5 clk = ~clk;

  ssd_scan_driver #(.DWELL(DW), .BLINK_HALF(BH)) dut (
    .clk        (clk),
    .rst        (rst),
    .ssd        (ssd),
    .blink_mask (blink_mask),
    .an         (an),
    .seg        (seg)
  );

  typedef struct packed {
    logic [19:0] ssd;
    logic [3:0]  mask;
    logic [27:0] g;     // expected glyphs {digit3,digit2,digit1,digit0}
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   blink_en;

  task automatic check(input string name, input logic [3:0] a, input logic [6:0] s, input exp_t e);
    checks++;
    if (a !== e.an || s !== e.seg) begin
      failures++;
      $display("FAIL %s: an=%b seg=%b required an=%b seg=%b at %0t", name, a, s, e.an, e.seg, $time);
    end
  endtask

  task automatic push_frame(input logic [27:0] g, input logic [3:0] mask, input bit dark);
    for (int d = 3; d >= 0; d--) begin
      q.push_back('{an: 4'b1111, seg: 7'h7F});
      for (int c = 1; c < DW; c++) begin
        if (dark && mask[d]) q.push_back('{an: 4'b1111, seg: 7'h7F});
        else q.push_back('{an: ~(4'b0001 << d), seg: g[d*7 +: 7]});
      end
    end
  endtask

  task automatic step_check(input string name);
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty, an=%b seg=%b", name, an, seg);
    end else begin
      e = q.pop_front();
      check(name, an, seg, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef SSD_SCAN_DRIVER_BLINK_EN
    blink_en = 1'b1;
`else
    blink_en = 1'b0;
`endif
    vecs[0] = '{ssd: {5'd12, 5'd16, 5'd17, 5'd13}, mask: 4'b0000,
                g: {7'b1000110, 7'b1000111, 7'b0010010, 7'b0100001}};
    vecs[1] = '{ssd: {5'd18, 5'd19, 5'd14, 5'd20}, mask: 4'b1000,
                g: {7'b1000000, 7'b0001100, 7'b0000110, 7'b0101011}};
    vecs[2] = '{ssd: {5'd8, 5'd8, 5'd8, 5'd8}, mask: 4'b1000,
                g: {7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000}};
    vecs[3] = '{ssd: {5'd24, 5'd25, 5'd30, 5'd31}, mask: 4'b0000,
                g: {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
    vecs[4] = '{ssd: {5'd0, 5'd1, 5'd2, 5'd3}, mask: 4'b0101,
                g: {7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000}};
    vecs[5] = '{ssd: {5'd4, 5'd5, 5'd6, 5'd7}, mask: 4'b1000,
                g: {7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000}};
    vecs[6] = '{ssd: {5'd9, 5'd10, 5'd11, 5'd15}, mask: 4'b1000,
                g: {7'b0010000, 7'b0001000, 7'b0000011, 7'b0001110}};
    vecs[7] = '{ssd: {5'd21, 5'd22, 5'd23, 5'd10}, mask: 4'b1000,
                g: {7'b0111111, 7'h7F, 7'b1000001, 7'b0001000}};

    rst = 1'b1;
    ssd = vecs[0].ssd;
    blink_mask = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", an, seg, '{an: 4'b1111, seg: 7'h7F});
    @(negedge clk);
    rst = 1'b0;

    // Frame 0 after reset shows blanks; frame i+1 shows vecs[i] (snapshot at the end of frame i).
    push_frame({4{7'h7F}}, 4'b0000, 1'b0);
    for (int i = 0; i < NVEC; i++) begin
      push_frame(vecs[i].g, vecs[i].mask, blink_en && (((i + 1) % 2) == 1));
      for (int c = 0; c < FRAME; c++) begin
        // Mid-frame change: the frame on screen must still finish with the old value.
        if (c == FRAME / 2) begin
          ssd = vecs[i].ssd;
          blink_mask = vecs[i].mask;
        end
        step_check($sformatf("frame%0d_c%0d", i, c));
      end
    end

    // Run into frame 8 up to dwell count 2 of digit 1, then reset asynchronously.
    for (int c = 0; c < 2 * DW + 2; c++) step_check($sformatf("frame8_c%0d", c));
    rst = 1'b1;
    #1;
    check("async_reset", an, seg, '{an: 4'b1111, seg: 7'h7F});
    q.delete();
    @(posedge clk);
    #1;
    check("reset_edge", an, seg, '{an: 4'b1111, seg: 7'h7F});
    @(negedge clk);
    rst = 1'b0;

    push_frame({4{7'h7F}}, 4'b0000, 1'b0);
    push_frame(vecs[7].g, vecs[7].mask, blink_en);
    for (int c = 0; c < 2 * FRAME; c++) step_check($sformatf("post_reset_c%0d", c));

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
